inst_cache_lines: RTL and testbench
===================================

// Module: inst_cache_lines
// PURPOSE
//  Parametrised direct-mapped instruction cache with multi-word lines, sitting between the fetch
//  stage (PC in, instruction out, miss -> pipeline stall) and instruction RAM. A miss refills the
//  whole line as a word burst over the readRAM/ramReady handshake. Adds flush and hit/miss
//  counters for cache analysis.
// PARAMETERS
//  LINES           32  number of cache lines, power of 2, >=2
//  WORDS_PER_LINE   4  32-bit words per line, power of 2, >=1
//  ADDR_W          32  byte-address width
//  CNT_W           64  width of hit/miss statistic counters
//  derived: OFF_W=log2(WORDS_PER_LINE), IDX_W=log2(LINES), TAG_W=ADDR_W-IDX_W-OFF_W-2
// PORTS
//  clock      in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high
//  address    in   ADDR_W  fetch byte address; bits[1:0] ignored
//  stall      in   1       pipeline stall; forces outData to 0, no hit counted
//  flush      in   1       invalidate all lines (1-cycle pulse)
//  outData    out  32      instruction word, big-endian as stored
//  miss       out  1       1 = outData not valid this cycle
//  readRAM    out  1       RAM read request, level
//  ramAddr    out  ADDR_W  word address of current fill beat, bits[1:0]=0
//  outRAM     in   32      RAM read data
//  ramReady   in   1       outRAM valid for ramAddr this cycle
//  hitCount   out  CNT_W   lookups hit in IDLE with stall=0
//  missCount  out  CNT_W   line fills started
// BEHAVIOUR
//  address split: tag=[ADDR_W-1 -: TAG_W], index=[IDX_W+OFF_W+1 : OFF_W+2], word=[OFF_W+1:2].
//  hit = valid[index] && tag_arr[index]==tag (combinational); miss = !(hit && state==IDLE).
//  outData = stall ? 0 : data[index][word], combinational, zero-latency on hit.
//  Reset: state IDLE, all valid=0, readRAM=0, ramAddr=0, beat cnt=0, flush_pend=0, counters=0;
//   data/tag contents need not be cleared. Reset mid-fill aborts fill; no line becomes valid.
//  FSM IDLE:
//   - flush=1: clear all valid at edge; no fill started this cycle, even on a miss.
//   - else hit: stay; hitCount+1 if stall=0.
//   - else miss: latch tag/index, beat=0, ramAddr={tag,index,OFF_W'0,2'b00}, readRAM<=1,
//     missCount+1, -> FILL. Miss fills regardless of stall.
//  FSM FILL:
//   - each cycle ramReady=1: data[lat_index][beat]<=outRAM, beat+1, ramAddr+4.
//   - ramReady=1 on beat==WORDS_PER_LINE-1: valid[lat_index]<=!flush_pend && !flush,
//     tag_arr[lat_index]<=lat_tag, readRAM<=0, flush_pend<=0, all valid cleared if pending, ->IDLE.
//   - ramReady=0: hold, readRAM stays 1, ramAddr stable.
//   - flush in FILL sets flush_pend; applied at fill end (all valid incl. new line cleared).
//   - address changes during FILL ignored; fill uses latched tag/index; miss held 1.
//  Tag/valid written only at final beat: partial line never hits.
//  Miss penalty with zero-wait RAM: WORDS_PER_LINE+1 cycles of miss=1, hit on next cycle.
//  Counters wrap modulo 2^CNT_W. Same-edge valid write and flush: flush wins.
// TESTING
//  1 reset, address=0x100, ramReady=1 every cycle -> readRAM=1, ramAddr 0x100,0x104,0x108,0x10C,
//    miss=1 for 5 cycles, then miss=0, outData=word@0x100, missCount=1.
//  2 after 1, address 0x104,0x108,0x10C in turn -> miss=0 each cycle, hitCount=3, no readRAM.
//  3 conflict: 0x100 then 0x100+LINES*16 -> second misses, refills same index; 0x100 misses again.
//  4 ramReady low 3 cycles between beats -> ramAddr/beat hold, readRAM stays 1, data correct.
//  5 flush pulse mid-fill of 0x200 -> fill completes, readRAM drops, 0x200 then misses (refill).
//  6 reset asserted at beat 2 of a fill -> readRAM=0, counters=0, address 0x100 misses afterward.

Source files
------------

// File: rtl/inst_cache_lines_if.sv
// Fetch-side and RAM-side signals of the instruction cache, bundled as one bus.
//
// Handshake: the cache holds readRAM high with a stable ramAddr for as long as a
// line fill is in progress; the RAM answers by raising ramReady for one cycle per
// word, with outRAM valid for the current ramAddr in that same cycle. The cache
// takes the word at that rising edge and moves ramAddr on to the next word.
interface inst_cache_lines_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 64
);
    logic [ADDR_W-1:0] address;
    logic              stall;
    logic              flush;
    logic [31:0]       outData;
    logic              miss;
    logic              readRAM;
    logic [ADDR_W-1:0] ramAddr;
    logic [31:0]       outRAM;
    logic              ramReady;
    logic [CNT_W-1:0]  hitCount;
    logic [CNT_W-1:0]  missCount;
    logic              fsm_state;   // 0 = IDLE, 1 = FILL

    modport slave (
        input  address, stall, flush, outRAM, ramReady,
        output outData, miss, readRAM, ramAddr, hitCount, missCount, fsm_state
    );

    modport master (
        output address, stall, flush, outRAM, ramReady,
        input  outData, miss, readRAM, ramAddr, hitCount, missCount, fsm_state
    );
endinterface

// File: rtl/inst_cache_lines.sv
// Direct-mapped instruction cache with multi-word lines. Hits return the word
// combinationally; a miss refills the whole line as a word burst from RAM.
// Tag and valid are only written on the last beat, so a partly filled line can
// never hit. Hit and miss counters support cache analysis.
module inst_cache_lines #(
    parameter int LINES          = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32,
    parameter int CNT_W          = 64
) (
    input logic                 clock,
    input logic                 reset,
    inst_cache_lines_if.slave   bus
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam int BW    = (OFF_W > 0) ? OFF_W : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(WORDS_PER_LINE * 4 - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(WORDS_PER_LINE - 1);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(WORDS_PER_LINE - 1);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [31:0]       data_arr [LINES][WORDS_PER_LINE];

    logic [TAG_W-1:0]  lat_tag;
    logic [IDX_W-1:0]  lat_idx;
    logic [BW-1:0]     beat_q;
    logic              flush_pend;
    logic              read_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [CNT_W-1:0]  hit_cnt, miss_cnt;

    logic [TAG_W-1:0]  addr_tag;
    logic [IDX_W-1:0]  addr_idx;
    logic [BW-1:0]     addr_word;
    logic              hit;

    logic start_fill, count_hit, clear_idle, beat_fire, last_fire;

    // Split the fetch address and perform the tag lookup.
    always_comb begin
        addr_tag  = TAG_W'(bus.address >> (IDX_W + OFF_W + 2));
        addr_idx  = IDX_W'(bus.address >> (OFF_W + 2));
        addr_word = BW'((bus.address >> 2) & WORD_MASK);
        hit       = valid_q[addr_idx] && (tag_arr[addr_idx] == addr_tag);
    end

    assign bus.miss      = !(hit && (state_q == IDLE));
    assign bus.outData   = bus.stall ? 32'd0 : data_arr[addr_idx][addr_word];
    assign bus.readRAM   = read_q;
    assign bus.ramAddr   = ram_addr_q;
    assign bus.hitCount  = hit_cnt;
    assign bus.missCount = miss_cnt;
    assign bus.fsm_state = state_q;

    // Next-state and control decode; flush in IDLE takes priority over a fill.
    always_comb begin
        state_d    = state_q;
        start_fill = 1'b0;
        count_hit  = 1'b0;
        clear_idle = 1'b0;
        beat_fire  = 1'b0;
        last_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    clear_idle = 1'b1;
                end else if (hit) begin
                    count_hit = !bus.stall;
                end else begin
                    start_fill = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (bus.ramReady) begin
                    beat_fire = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        last_fire = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Fill control: latched line, beat counter, RAM request and statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_tag    <= '0;
            lat_idx    <= '0;
            beat_q     <= '0;
            flush_pend <= 1'b0;
            read_q     <= 1'b0;
            ram_addr_q <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            if (count_hit) hit_cnt <= hit_cnt + CNT_W'(1);
            if (start_fill) begin
                lat_tag    <= addr_tag;
                lat_idx    <= addr_idx;
                beat_q     <= '0;
                ram_addr_q <= bus.address & ~LINE_MASK;
                read_q     <= 1'b1;
                miss_cnt   <= miss_cnt + CNT_W'(1);
            end
            if (beat_fire) begin
                beat_q     <= beat_q + BW'(1);
                ram_addr_q <= ram_addr_q + ADDR_W'(4);
            end
            if (last_fire) begin
                read_q     <= 1'b0;
                flush_pend <= 1'b0;
            end else if (state_q == FILL && bus.flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // Valid bits: a flush (immediate or pending) always beats a new line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (clear_idle) begin
            valid_q <= '0;
        end else if (last_fire) begin
            if (flush_pend || bus.flush) valid_q <= '0;
            else                         valid_q[lat_idx] <= 1'b1;
        end
    end

    // Line storage: data per beat, tag on the final beat.
    always_ff @(posedge clock) begin
        if (beat_fire) data_arr[lat_idx][beat_q] <= bus.outRAM;
        if (last_fire) tag_arr[lat_idx] <= lat_tag;
    end
endmodule

// File: tb/tb_inst_cache_lines.sv
// Directed bench for inst_cache_lines: fills, hits, conflicts, RAM wait states,
// flush during fill and in idle, and reset in the middle of a fill.
module tb_inst_cache_lines;
    localparam int LINES = 32;
    localparam int WPL   = 4;

    logic clock = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [63:0] exp_miss = 0;

    inst_cache_lines_if #(.ADDR_W(32), .CNT_W(64)) bus ();

    inst_cache_lines #(
        .LINES(LINES), .WORDS_PER_LINE(WPL), .ADDR_W(32), .CNT_W(64)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // RAM contents: a recognisable pattern derived from the word address.
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.outRAM = ram_word(bus.ramAddr);

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Fill a line with a zero-wait RAM, checking each beat and the first hit.
    task automatic fill_line(input logic [31:0] addr);
        bus.address  = addr;
        bus.stall    = 1'b1;
        bus.ramReady = 1'b1;
        #1;
        chk("fill_miss_idle", {63'd0, bus.miss}, 64'd1);
        for (int b = 0; b < WPL; b++) begin
            tick();
            chk("fill_readram", {63'd0, bus.readRAM}, 64'd1);
            chk("fill_ramaddr", {32'd0, bus.ramAddr}, {32'd0, addr + 32'(4 * b)});
            chk("fill_miss", {63'd0, bus.miss}, 64'd1);
        end
        tick();
        exp_miss++;
        chk("fill_done_miss", {63'd0, bus.miss}, 64'd0);
        chk("fill_done_readram", {63'd0, bus.readRAM}, 64'd0);
        chk("fill_misscount", bus.missCount, exp_miss);
        bus.stall = 1'b0;
        #1;
        chk("fill_outdata", {32'd0, bus.outData}, {32'd0, ram_word(addr)});
        bus.stall = 1'b1;
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.address  = 32'h0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.ramReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_readram", {63'd0, bus.readRAM}, 64'd0);
        chk("rst_ramaddr", {32'd0, bus.ramAddr}, 64'd0);
        chk("rst_hitcount", bus.hitCount, 64'd0);
        chk("rst_misscount", bus.missCount, 64'd0);
        chk("rst_miss", {63'd0, bus.miss}, 64'd1);
        chk("rst_state", {63'd0, bus.fsm_state}, 64'd0);
        reset = 1'b0;
        #1;

        // 1: cold miss at 0x100, five miss cycles, then hit.
        fill_line(32'h100);

        // 2: remaining words of the line hit without touching RAM.
        bus.stall = 1'b0;
        for (int i = 1; i < WPL; i++) begin
            bus.address = 32'h100 + 32'(4 * i);
            #1;
            chk("hit_miss", {63'd0, bus.miss}, 64'd0);
            chk("hit_outdata", {32'd0, bus.outData}, {32'd0, ram_word(32'h100 + 32'(4 * i))});
            chk("hit_readram", {63'd0, bus.readRAM}, 64'd0);
            tick();
        end
        bus.stall = 1'b1;
        #1;
        chk("hit_hitcount", bus.hitCount, 64'd3);
        chk("stall_outdata_zero", {32'd0, bus.outData}, 64'd0);

        // 3: conflicting line evicts 0x100, which then misses again.
        fill_line(32'h100 + 32'(LINES * 16));
        bus.address = 32'h100;
        #1;
        chk("conflict_evicted", {63'd0, bus.miss}, 64'd1);
        fill_line(32'h100);

        // 4: RAM wait states between beats.
        bus.address  = 32'h400;
        bus.stall    = 1'b1;
        bus.ramReady = 1'b1;
        #1;
        tick();
        tick();
        bus.ramReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_ramaddr", {32'd0, bus.ramAddr}, 64'h404);
            chk("wait_readram", {63'd0, bus.readRAM}, 64'd1);
            chk("wait_miss", {63'd0, bus.miss}, 64'd1);
        end
        bus.ramReady = 1'b1;
        tick();
        tick();
        chk("wait_resume_addr", {32'd0, bus.ramAddr}, 64'h40C);
        tick();
        exp_miss++;
        chk("wait_done_miss", {63'd0, bus.miss}, 64'd0);
        chk("wait_misscount", bus.missCount, exp_miss);
        bus.stall = 1'b0;
        for (int i = 0; i < WPL; i++) begin
            bus.address = 32'h400 + 32'(4 * i);
            #1;
            chk("wait_data", {32'd0, bus.outData}, {32'd0, ram_word(32'h400 + 32'(4 * i))});
        end
        bus.stall = 1'b1;
        #1;

        // 5: flush pulse in the middle of a fill of 0x200.
        bus.address = 32'h200;
        #1;
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        chk("flushfill_readram_held", {63'd0, bus.readRAM}, 64'd1);
        tick();
        exp_miss++;
        chk("flushfill_readram", {63'd0, bus.readRAM}, 64'd0);
        chk("flushfill_state", {63'd0, bus.fsm_state}, 64'd0);
        chk("flushfill_miss", {63'd0, bus.miss}, 64'd1);
        chk("flushfill_misscount", bus.missCount, exp_miss);
        bus.address = 32'h100;
        #1;
        chk("flushfill_other_line", {63'd0, bus.miss}, 64'd1);
        fill_line(32'h200);

        // Flush in IDLE on a hitting address: no hit counted, no fill started.
        bus.address = 32'h200;
        bus.stall   = 1'b0;
        bus.flush   = 1'b1;
        #1;
        chk("idleflush_pre_hit", {63'd0, bus.miss}, 64'd0);
        tick();
        bus.flush = 1'b0;
        bus.stall = 1'b1;
        #1;
        chk("idleflush_miss", {63'd0, bus.miss}, 64'd1);
        chk("idleflush_readram", {63'd0, bus.readRAM}, 64'd0);
        chk("idleflush_hitcount", bus.hitCount, 64'd3);

        // 6: reset at beat 2 of a fill aborts it.
        bus.address = 32'h100;
        #1;
        tick();
        tick();
        tick();
        chk("abort_beat2_addr", {32'd0, bus.ramAddr}, 64'h108);
        reset = 1'b1;
        #1;
        chk("abort_readram", {63'd0, bus.readRAM}, 64'd0);
        chk("abort_ramaddr", {32'd0, bus.ramAddr}, 64'd0);
        chk("abort_hitcount", bus.hitCount, 64'd0);
        chk("abort_misscount", bus.missCount, 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("abort_line_invalid", {63'd0, bus.miss}, 64'd1);
        tick();
        chk("abort_refill_req", {63'd0, bus.readRAM}, 64'd1);
        chk("abort_refill_addr", {32'd0, bus.ramAddr}, 64'h100);
        chk("abort_refill_count", bus.missCount, 64'd1);
        repeat (WPL) tick();
        bus.stall = 1'b0;
        #1;
        chk("abort_refill_hit", {63'd0, bus.miss}, 64'd0);
        chk("abort_refill_data", {32'd0, bus.outData}, {32'd0, ram_word(32'h100)});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
